// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory block port.
// Contents: FSM state encoding for the read side and block geometry
// constants (one block = 16 bytes = 128 bits).
package imem_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_BITS  = 128;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_BUSY = 2'd1,
        IMEM_DONE = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_byte_array.sv
// Byte-addressed storage for the instruction memory.
// Ports:
//   clock  in   rising-edge clock for the write port
//   we     in   byte write enable
//   waddr  in   byte write address
//   wdata  in   byte to write
//   raddr  in   block address for the read port
//   rdata  out  16-byte block, combinational, byte k at [8k+7:8k]
// Contents are not reset.
module imem_byte_array
    import imem_pkg::*;
#(
    parameter int BLOCK_ADDR_W = 6
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [BLOCK_ADDR_W+3:0] waddr,
    input  logic [7:0]              wdata,
    input  logic [BLOCK_ADDR_W-1:0] raddr,
    output logic [BLOCK_BITS-1:0]   rdata
);

    localparam int DEPTH = BLOCK_BYTES << BLOCK_ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < BLOCK_BYTES; k++) begin : g_block_read
        assign rdata[8*k +: 8] = mem[{raddr, 4'(k)}];
    end

endmodule

// File: rtl/instruction_memory_block_port.sv
// Backing instruction memory for the instruction cache.
// Serves one 16-byte block per request with a fixed latency over the
// cache's read/busywait interface, and accepts byte loads while idle.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   read        in   block read request, held until busywait falls
//   address     in   block address
//   readdata    out  registered block data, held until the next read completes
//   busywait    out  high while a request is pending or in service
//   load_en     in   byte write strobe
//   load_addr   in   byte address
//   load_data   in   byte data
//   load_stall  out  load_en presented while the read side is not free
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request in flight; busywait follows read; loads accepted
// BUSY  | serving latched address; counter runs down to the capture edge
// DONE  | block delivered; read ignored for one cycle (icache still holds it)
module instruction_memory_block_port
    import imem_pkg::*;
#(
    parameter int READ_LATENCY = 5,
    parameter int BLOCK_ADDR_W = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic [BLOCK_ADDR_W-1:0] address,
    output logic [BLOCK_BITS-1:0]   readdata,
    output logic                    busywait,
    input  logic                    load_en,
    input  logic [BLOCK_ADDR_W+3:0] load_addr,
    input  logic [7:0]              load_data,
    output logic                    load_stall
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    imem_state_e             state, state_next;
    logic [CNT_W-1:0]        counter;
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [BLOCK_ADDR_W-1:0] block_sel;
    logic [BLOCK_BITS-1:0]   block_data;
    logic                    busy_int;
    logic                    latch_addr;
    logic                    load_cnt;
    logic                    dec_cnt;
    logic                    clr_cnt;
    logic                    capture;
    logic                    load_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IMEM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_int   = 1'b0;
        latch_addr = 1'b0;
        load_cnt   = 1'b0;
        dec_cnt    = 1'b0;
        clr_cnt    = 1'b0;
        capture    = 1'b0;
        case (state)
            IMEM_IDLE: begin
                busy_int = read;
                if (read) begin
                    latch_addr = 1'b1;
                    if (READ_LATENCY == 1) begin
                        capture    = 1'b1;
                        state_next = IMEM_DONE;
                    end else begin
                        load_cnt   = 1'b1;
                        state_next = IMEM_BUSY;
                    end
                end
            end
            IMEM_BUSY: begin
                busy_int = 1'b1;
                if (counter == CNT_W'(1)) begin
                    capture    = 1'b1;
                    clr_cnt    = 1'b1;
                    state_next = IMEM_DONE;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            IMEM_DONE: begin
                state_next = IMEM_IDLE;
            end
            default: begin
                state_next = IMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter  <= '0;
            addr_q   <= '0;
            readdata <= '0;
        end else begin
            if (load_cnt) begin
                counter <= CNT_W'(READ_LATENCY - 1);
            end else if (clr_cnt) begin
                counter <= '0;
            end else if (dec_cnt) begin
                counter <= counter - CNT_W'(1);
            end
            if (latch_addr) begin
                addr_q <= address;
            end
            if (capture) begin
                readdata <= block_data;
            end
        end
    end

    // In IDLE the live address feeds the array so a single-cycle latency
    // can capture on the request edge; afterwards only the latched copy is used.
    assign block_sel = (state == IMEM_IDLE) ? address : addr_q;

    // Read wins over a simultaneous load, and nothing moves while in reset.
    assign load_ok    = load_en & ~reset & (state == IMEM_IDLE) & ~read;
    assign load_stall = load_en & ~reset & ~((state == IMEM_IDLE) & ~read);
    assign busywait   = busy_int & ~reset;

    imem_byte_array #(
        .BLOCK_ADDR_W(BLOCK_ADDR_W)
    ) u_array (
        .clock(clock),
        .we   (load_ok),
        .waddr(load_addr),
        .wdata(load_data),
        .raddr(block_sel),
        .rdata(block_data)
    );

endmodule

// File: tb/tb_instruction_memory_block_port.sv
module tb_instruction_memory_block_port;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [5:0]   address;
    logic [127:0] readdata;
    logic         busywait;
    logic         load_en;
    logic [9:0]   load_addr;
    logic [7:0]   load_data;
    logic         load_stall;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_pushed     = 0;
    int n_served     = 0;

    logic [127:0] exp_q [$];

    localparam logic [127:0] BLK0      = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] BLK0_MOD  = 128'h0F0E0D0C_0B0A0908_07060504_AA020100;
    localparam logic [127:0] BLK1      = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [127:0] BLK63     = 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0;

    instruction_memory_block_port dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .address   (address),
        .readdata  (readdata),
        .busywait  (busywait),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_stall(load_stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a completed service is a busywait high run ending outside reset.
    int run_len = 0;
    logic prev_bw = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            run_len = 0;
            prev_bw = 1'b0;
        end else begin
            if (busywait) begin
                run_len++;
            end else if (prev_bw) begin
                n_served++;
                if (exp_q.size() == 0) begin
                    check("unexpected_service", 128'd1, 128'd0);
                end else begin
                    check("readdata", readdata, exp_q.pop_front());
                    check("latency", 128'(run_len), 128'd5);
                end
                run_len = 0;
            end
            prev_bw = busywait;
        end
    end

    task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clock);
        #1;
        load_en = 1'b0;
    endtask

    // mode 0: plain; 1: address moves to 5 during BUSY; 2: stalled load during BUSY
    task automatic do_read(input logic [5:0] a, input logic [127:0] exp, input int mode);
        int guard;
        exp_q.push_back(exp);
        n_pushed++;
        read    = 1'b1;
        address = a;
        @(posedge clock);
        #1;
        if (mode == 1) address = 6'd5;
        if (mode == 2) begin
            load_en   = 1'b1;
            load_addr = 10'd3;
            load_data = 8'hAA;
            #1;
            check("load_stall_busy", 128'(load_stall), 128'd1);
        end
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (busywait && guard < 50);
        if (guard >= 50) check("read_timeout", 128'd1, 128'd0);
        load_en = 1'b0;
        // icache still holds read through the DONE edge
        @(posedge clock);
        #1;
        check("idle_bw_follows_read", 128'(busywait), 128'd1);
        read = 1'b0;
        #1;
        check("idle_bw_low", 128'(busywait), 128'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        read      = 1'b1;
        address   = '0;
        load_en   = 1'b1;
        load_addr = '0;
        load_data = '0;
        #12;
        check("reset_readdata", readdata, 128'd0);
        check("reset_busywait", 128'(busywait), 128'd0);
        check("reset_load_stall", 128'(load_stall), 128'd0);
        read    = 1'b0;
        load_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Test 1: fill blocks 0 and 1, read block 0
        for (int i = 0; i < 32; i++) load_byte(10'(i), 8'(i));
        do_read(6'd0, BLK0, 0);

        // Test 2: read held through DONE yields one service, no restart
        do_read(6'd1, BLK1, 0);
        repeat (8) @(posedge clock);
        #1;
        check("single_service", 128'(n_served), 128'(n_pushed));

        // Test 3: address change during BUSY ignored
        do_read(6'd0, BLK0, 1);

        // Test 4: load stalled in BUSY, accepted in IDLE
        do_read(6'd0, BLK0, 2);
        do_read(6'd0, BLK0, 0);
        load_en   = 1'b1;
        load_addr = 10'd3;
        load_data = 8'hAA;
        #1;
        check("load_stall_idle", 128'(load_stall), 128'd0);
        @(posedge clock);
        #1;
        load_en = 1'b0;
        do_read(6'd0, BLK0_MOD, 0);

        // Test 5: reset during third BUSY cycle aborts the read
        read    = 1'b1;
        address = 6'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        read  = 1'b0;
        #1;
        check("abort_busywait", 128'(busywait), 128'd0);
        check("abort_readdata", readdata, 128'd0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        do_read(6'd1, BLK1, 0);

        // Test 6: top block, no wrap
        for (int i = 0; i < 16; i++) load_byte(10'(1008 + i), 8'(8'hF0 + i));
        do_read(6'd63, BLK63, 0);
        repeat (4) @(posedge clock);
        #1;
        check("readdata_held", readdata, BLK63);
        check("all_served", 128'(n_served), 128'(n_pushed));
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
